// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param
//   Parametrised UART transmitter with an integrated TX FIFO and break
//   generation. Words are pushed through a valid/ready port, popped into a
//   shift register when the serialiser is idle, and sent LSB first on `tx`
//   with optional parity and one or two stop bits. Bit timing comes from an
//   external one-clock `baud_tick` strobe.
//
// Ports
//   clk, aresetn      clock, asynchronous active-low reset
//   baud_tick         one-clk strobe per bit period
//   s_valid/s_ready   write handshake (s_ready = !full)
//   s_data            word to send, LSB first
//   cfg_nbits         data bits per frame (5..DATA_W, else DATA_W)
//   cfg_parity        00 none, 01 even, 10 odd, 11 mark
//   cfg_stop2         0 = one stop bit, 1 = two stop bits
//   send_break        level request to hold tx low
//   tx                serial output, idles high
//   busy              FSM not idle or FIFO non-empty
//   tx_done           one-clk pulse at the end of each frame
//   fifo_level        FIFO occupancy
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              baud_tick,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [3:0]        cfg_nbits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              send_break,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;

  // ---------------------------------------------------------------- FIFO
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] rd_word;

  assign level_q = wr_ptr_q - rd_ptr_q;
  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push    = s_valid && !full;
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
  assign level_d  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= s_data;
  end

  // ------------------------------------------------- frame configuration
  logic [3:0]        nbits_eff;
  logic [DATA_W-1:0] nbit_mask;
  logic              data_xor, par_calc;

  assign nbits_eff = (cfg_nbits < 4'd5 || cfg_nbits > 4'(DATA_W)) ?
                     4'(DATA_W) : cfg_nbits;

  // Parity covers only the bits that will actually be sent.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign nbit_mask[gi] = (nbits_eff > 4'(gi));
  end

  assign data_xor = ^(rd_word & nbit_mask);

  always_comb begin
    case (cfg_parity)
      2'b01:   par_calc = data_xor;
      2'b10:   par_calc = ~data_xor;
      default: par_calc = 1'b1;
    endcase
  end

  // ----------------------------------------------------------------- FSM
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              tx_done_q, tx_done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending break wins over queued data.
        if (send_break) begin
          state_d = S_BREAK;
        end else if (!empty) begin
          pop       = 1'b1;
          shift_d   = rd_word;
          nbits_d   = nbits_eff;
          par_en_d  = (cfg_parity != 2'b00);
          par_bit_d = par_calc;
          stop2_d   = cfg_stop2;
          state_d   = S_ARM;
        end
      end
      // Start edge waits for the next tick so it lands on the bit grid.
      S_ARM: if (baud_tick) begin
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: if (baud_tick) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = 4'd1;
        state_d = S_DATA;
      end
      S_DATA: if (baud_tick) begin
        if (cnt_q < nbits_q) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 4'd1;
        end else if (par_en_q) begin
          tx_d    = par_bit_q;
          state_d = S_PARITY;
        end else begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_PARITY: if (baud_tick) begin
        tx_d       = 1'b1;
        stop_cnt_d = 1'b0;
        state_d    = S_STOP;
      end
      S_STOP: if (baud_tick) begin
        if (stop2_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_BREAK: if (baud_tick) begin
        if (send_break) begin
          tx_d = 1'b0;
        end else begin
          tx_d    = 1'b1;
          state_d = S_MARK;
        end
      end
      // One full bit period of mark after a break before new data.
      S_MARK: if (baud_tick) begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      busy_q     <= busy_d;
    end
  end

  assign s_ready    = !full;
  assign fifo_level = LVL_W'(level_q);
  assign tx         = tx_q;
  assign tx_done    = tx_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param
//   Self-checking bench for uart_tx_fifo_param (DATA_W=9, FIFO_DEPTH=4).
//   Expected serial frames are built from the frame rules (start, nbits data
//   LSB first, optional parity, stop bits) and compared bit by bit with `tx`
//   sampled just after each baud tick.
module tb_uart_tx_fifo_param;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              baud_tick = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic [3:0]        cfg_nbits = 4'd8;
  logic [1:0]        cfg_parity = 2'b00;
  logic              cfg_stop2 = 1'b0;
  logic              send_break = 1'b0;
  logic              tx, busy, tx_done;
  logic [LVL_W-1:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_period = 16;
  bit tick_en = 1'b0;
  bit exp_q[$];

  uart_tx_fifo_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .aresetn(aresetn), .baud_tick(baud_tick),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_nbits(cfg_nbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .send_break(send_break), .tx(tx), .busy(busy), .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Baud strobe: one clk high every tick_period clks while enabled.
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        if (cnt >= tick_period - 1) begin
          baud_tick = 1'b1;
          cnt = 0;
        end else begin
          baud_tick = 1'b0;
          cnt++;
        end
      end else begin
        baud_tick = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_nbits(input logic [3:0] raw);
    int r;
    r = int'(raw);
    return (r < 5 || r > DATA_W) ? DATA_W : r;
  endfunction

  // Reference frame: list of line levels, one per bit period.
  function automatic void build_frame(input logic [8:0] w, input logic [3:0] raw,
                                      input logic [1:0] par, input logic st2);
    int nb;
    bit p;
    nb = eff_nbits(raw);
    p  = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(w[i]);
      p = p ^ w[i];
    end
    if (par == 2'b01)      exp_q.push_back(p);
    else if (par == 2'b10) exp_q.push_back(!p);
    else if (par == 2'b11) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    if (st2) exp_q.push_back(1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int g;
    g = 0;
    do begin
      step();
      g++;
    end while (!baud_tick && g < 4000);
    if (!baud_tick) check_eq($sformatf("%s tick_timeout", tag), 0, 1);
  endtask

  task automatic push_word(input logic [8:0] w);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Waits for the start edge, then checks every bit level, bit length and
  // the tx_done pulse against exp_q.
  task automatic expect_frame(input string tag);
    int guard;
    int cyc;
    bit ok;
    guard = 0;
    while (tx !== 1'b0 && guard < 4000) begin
      step();
      guard++;
    end
    if (tx !== 1'b0) begin
      check_eq($sformatf("%s start_timeout", tag), 0, 1);
      return;
    end
    check_eq($sformatf("%s start_on_tick", tag), 32'(baud_tick), 1);
    check_eq($sformatf("%s busy", tag), 32'(busy), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(exp_q[i]));
      ok  = (tx_done === 1'b0);
      cyc = 0;
      do begin
        step();
        cyc++;
        if (!baud_tick && (tx !== exp_q[i] || tx_done !== 1'b0)) ok = 1'b0;
      end while (!baud_tick && cyc < 4000);
      check_eq($sformatf("%s hold%0d", tag, i), 32'(ok), 1);
      check_eq($sformatf("%s len%0d", tag, i), cyc, tick_period);
    end
    check_eq($sformatf("%s done", tag), 32'(tx_done), 1);
    check_eq($sformatf("%s stop_level", tag), 32'(tx), 1);
    step();
    check_eq($sformatf("%s done_pulse", tag), 32'(tx_done), 0);
  endtask

  initial begin : main
    logic [8:0] w;
    logic [3:0] raw;
    logic [1:0] par;
    logic       st;
    logic [8:0] fill_w [5];
    int         periods [5];
    int         cyc;
    bit         ok;

    periods = '{1, 2, 3, 7, 16};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst tx", 32'(tx), 1);
    check_eq("rst s_ready", 32'(s_ready), 1);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst tx_done", 32'(tx_done), 0);
    check_eq("rst level", 32'(fifo_level), 0);
    aresetn = 1'b1;

    // Directed frames
    tick_period = 16;
    tick_en = 1'b1;
    cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    build_frame(9'h055, 4'd8, 2'b00, 1'b0);
    push_word(9'h055);
    expect_frame("8n1_55");
    check_eq("8n1_55 busy_fall", 32'(busy), 0);

    cfg_nbits = 4'd7; cfg_parity = 2'b01;
    build_frame(9'h041, 4'd7, 2'b01, 1'b0);
    push_word(9'h041);
    expect_frame("7e1_41");

    cfg_parity = 2'b10;
    build_frame(9'h041, 4'd7, 2'b10, 1'b0);
    push_word(9'h041);
    expect_frame("7o1_41");

    cfg_nbits = 4'd9; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    build_frame(9'h1FF, 4'd9, 2'b10, 1'b1);
    push_word(9'h1FF);
    expect_frame("9o2_1ff");

    // Out-of-range nbits clamps to DATA_W
    cfg_nbits = 4'd15; cfg_parity = 2'b11; cfg_stop2 = 1'b0;
    build_frame(9'h1A5, 4'd15, 2'b11, 1'b0);
    push_word(9'h1A5);
    expect_frame("clamp_1a5");

    // Random frames; cfg is scrambled after the pop and must not matter
    for (int it = 0; it < 12; it++) begin
      tick_period = periods[$urandom_range(0, 4)];
      w   = 9'($urandom);
      raw = 4'($urandom_range(0, 15));
      par = 2'($urandom_range(0, 3));
      st  = 1'($urandom_range(0, 1));
      cfg_nbits = raw; cfg_parity = par; cfg_stop2 = st;
      build_frame(w, raw, par, st);
      push_word(w);
      fork
        expect_frame($sformatf("rnd%0d", it));
        begin
          repeat (3) @(negedge clk);
          cfg_nbits  = 4'($urandom);
          cfg_parity = 2'($urandom);
          cfg_stop2  = 1'($urandom);
        end
      join
      check_eq($sformatf("rnd%0d busy_fall", it), 32'(busy), 0);
    end

    // FIFO fill with ticks held off
    tick_en = 1'b0;
    tick_period = 16;
    cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) fill_w[k] = 9'($urandom_range(0, 255));
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = fill_w[k];
      check_eq($sformatf("fill ready%0d", k), 32'(s_ready), 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check_eq("fill level_full", 32'(fifo_level), 4);
    check_eq("fill s_ready_low", 32'(s_ready), 0);
    s_valid = 1'b1;
    s_data  = 9'h1EE;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check_eq("fill no_overflow", 32'(fifo_level), 4);
    tick_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      build_frame(fill_w[k], 4'd8, 2'b00, 1'b0);
      expect_frame($sformatf("fill%0d", k));
      check_eq($sformatf("fill%0d level", k), 32'(fifo_level), (k < 4) ? 3 - k : 0);
    end
    check_eq("fill busy_fall", 32'(busy), 0);

    // Break requested mid-frame with a word queued behind it
    tick_period = 8;
    build_frame(9'h03C, 4'd8, 2'b00, 1'b0);
    push_word(9'h03C);
    fork
      expect_frame("brk_a");
      begin
        repeat (40) @(negedge clk);
        send_break = 1'b1;
        push_word(9'h0A3);
      end
    join
    check_eq("brk idle_high", 32'(tx), 1);
    wait_tick("brk first");
    check_eq("brk low0", 32'(tx), 0);
    for (int n = 1; n < 4; n++) begin
      wait_tick("brk hold");
      check_eq($sformatf("brk low%0d", n), 32'(tx), 0);
    end
    check_eq("brk queued", 32'(fifo_level), 1);
    @(negedge clk);
    send_break = 1'b0;
    wait_tick("brk release");
    check_eq("brk release_high", 32'(tx), 1);
    cyc = 0;
    while (tx === 1'b1 && cyc < 4000) begin
      step();
      cyc++;
    end
    check_eq("brk mark_len", cyc, 2 * tick_period);
    build_frame(9'h0A3, 4'd8, 2'b00, 1'b0);
    expect_frame("brk_b");
    check_eq("brk busy_fall", 32'(busy), 0);

    // Asynchronous reset in the middle of the data bits
    tick_period = 4;
    push_word(9'h000);
    push_word(9'h0FF);
    cyc = 0;
    while (tx !== 1'b0 && cyc < 4000) begin
      step();
      cyc++;
    end
    repeat (3) wait_tick("rst mid");
    check_eq("rst_mid pre_tx", 32'(tx), 0);
    check_eq("rst_mid pre_level", 32'(fifo_level), 1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("rst_mid tx", 32'(tx), 1);
    check_eq("rst_mid level", 32'(fifo_level), 0);
    check_eq("rst_mid s_ready", 32'(s_ready), 1);
    check_eq("rst_mid busy", 32'(busy), 0);
    ok = 1'b1;
    repeat (8) begin
      step();
      if (tx !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
    end
    @(negedge clk);
    aresetn = 1'b1;
    repeat (40) begin
      step();
      if (tx !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
    end
    check_eq("rst_mid quiet", 32'(ok), 1);
    cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    build_frame(9'h0C3, 4'd8, 2'b01, 1'b1);
    push_word(9'h0C3);
    expect_frame("rst_after");
    check_eq("rst_after busy_fall", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
# uart_tx_fifo_param

Parametrised UART transmitter: the next generation of the CoreUART TX path, with configurable data width, parity mode, stop-bit count, an integrated TX FIFO with a valid/ready write port, and break generation. It sits between the bus-side register block, which pushes bytes, and the pad-level `tx` line. Bit timing comes from an external one-clock `baud_tick` strobe, one per bit period.

## Interface

Parameters:
- `DATA_W`, default 8: maximum data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, default 16: TX FIFO entries; power of 2, ≥2.
- `LVL_W`, default $clog2(FIFO_DEPTH+1): width of `fifo_level`.

Ports:
- `clk`  in  1  system clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `baud_tick`  in  1  one-`clk` strobe per bit period.
- `s_valid`  in  1  write data valid.
- `s_ready`  out  1  FIFO can accept a word; equals `!full`.
- `s_data`  in  DATA_W  word to transmit; LSB is sent first.
- `cfg_nbits`  in  4  data bits per frame, 5..DATA_W; out-of-range values are clamped to DATA_W.
- `cfg_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 mark (parity bit is constant 1).
- `cfg_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `send_break`  in  1  level request to hold `tx` low.
- `tx`  out  1  serial output; idles high.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- `tx_done`  out  1  one-`clk` pulse at the end of each frame's last stop bit.
- `fifo_level`  out  LVL_W  current number of FIFO entries.

## Operation

FIFO:
- A write occurs when `s_valid && s_ready`.
- A pop occurs only from the IDLE state when the FIFO is non-empty and no break is pending.
- A write and a pop in the same cycle leave `fifo_level` unchanged.
- When the FIFO is full, `s_ready` is 0, even if a pop happens in the same cycle. A write is never accepted into a full FIFO.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, ARM, START, DATA, PARITY, STOP, BREAK, MARK.
- **IDLE** (`tx`=1):
  - If `send_break` is high, go to BREAK.
  - Otherwise, if the FIFO is non-empty, pop the word into the shift register. In the same cycle, latch `cfg_nbits`, `cfg_parity` and `cfg_stop2` into frame registers, then go to ARM.
- **ARM**: wait for `baud_tick`. On the tick, drive `tx`←0 and go to START. This aligns the start edge to the bit grid.
- **START**: on the tick, drive `tx`←shift[0], shift right, set bit count←1, go to DATA.
- **DATA**:
  - On each tick, if count < nbits: drive the next bit and increment count.
  - Otherwise: if parity is enabled, drive `tx`←parity and go to PARITY; else drive `tx`←1 and go to STOP.
- **PARITY**: on the tick, drive `tx`←1 and go to STOP.
- **STOP**:
  - With two stop bits, the first tick stays in STOP.
  - The final tick pulses `tx_done` and goes to IDLE.
  - `tx` stays 1.
- **BREAK** (`tx`=0, applied on the next tick):
  - `tx` is held low while `send_break` is high.
  - After deassertion, the next tick drives `tx`←1 and goes to MARK.
- **MARK**: hold `tx`=1 for one full bit period (one tick), then go to IDLE.

Parity rules:
- Parity is computed over the low `nbits` bits only.
- even = XOR of those bits; odd = ~XOR; mark = 1.

Boundary and ordering rules:
- Changes to `cfg_*` during a frame are ignored until the next pop.
- `send_break` asserted mid-frame takes effect only after the current frame's STOP completes. Break has priority over a non-empty FIFO at IDLE.
- Assertion of `aresetn` at any point forces `tx`=1 immediately, empties the FIFO, and puts the FSM in IDLE.

## Timing

- Reset values:
  - `tx`=1, `s_ready`=1, `busy`=0, `tx_done`=0, `fifo_level`=0.
  - All state and registers cleared.
- `tx`, `tx_done` and `busy` are registered. `s_ready` and `fifo_level` are derived from registered pointers.
- Latency from write to start edge:
  - IDLE→pop takes 1 `clk`.
  - ARM waits up to one bit period for the next tick.
- Every bit lasts exactly one tick interval. `tx` changes only on the `clk` where `baud_tick`=1, except at reset.
- Frame length in ticks = 1 + nbits + (parity?1:0) + (stop2?2:1).
- Back-to-back frames: the next word pops one `clk` after `tx_done`, and the next start bit begins on the following tick. There is no extra idle bit between frames.
- `baud_tick` asserted in consecutive cycles must be handled. Each assertion counts as a bit boundary.

## Test plan

- **8N1, byte 0x55**, `baud_tick` every 16 clk:
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each bit 16 clk.
  - One `tx_done` pulse after the 10th tick; `busy` then falls.
- **7E1, byte 0x41** (`cfg_nbits`=7, `cfg_parity`=01):
  - Bits are start 0, then 1,0,0,0,0,0,1, parity 0, stop 1.
  - Repeat with odd parity: parity bit = 1.
- **DATA_W=9, word 0x1FF, odd parity, two stop bits**:
  - 13 bit periods total.
  - Parity bit = 0.
  - Two stop bits high before `tx_done`.
- **FIFO fill** (FIFO_DEPTH=4, ticks held off):
  - 5 words are accepted: one is popped to ARM, then 4 fill the FIFO.
  - `s_ready` then drops.
  - After restarting ticks, all 5 words transmit in order, with `tx_done` ×5.
  - `fifo_level` counts down to 0.
- **Break**:
  - Assert `send_break` mid-frame: the frame completes, then `tx` goes low on the next tick and stays low for N ticks.
  - Deassert: `tx`=1 for 2 tick periods (deassert tick plus MARK), then the queued word starts.
- **Reset mid-DATA**:
  - `tx` goes to 1 asynchronously.
  - `fifo_level`=0; no `tx_done` pulse.
  - A new write after release transmits a correct frame.
